// File: rtl/regfile_wb_scheduler.sv
// Purpose: arbitrates the register-file write port between pipeline writeback and buffered LLU results, with a pending scoreboard.
// Latency: write port is combinational (0 cycles); an LLU result is buffered and written no earlier than the cycle after it arrives.
// Backpressure: o_llu_ready drops when the result FIFO is full; o_llu_issue_rdy drops on outstanding limit or pending rd.
//
// Ports:
//   i_clk / i_arst                 clock, asynchronous active-low reset
//   i_wb_*                         in-order pipeline writeback (always wins the port)
//   i_llu_issue*, o_llu_issue_rdy  LLU dispatch handshake, marks rd pending
//   i_llu_valid/rd/data, o_llu_ready  LLU result handshake into the FIFO
//   i_dec_*, o_stall_decode        decode hazard check against pending registers
//   o_req_bubble                   asks the hazard unit for one writeback bubble
//   o_reg_we / o_rd_addr / o_rd_write_data  register-file write port
module regfile_wb_scheduler #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_llu_issue,
    input  logic [REG_ADDR_W-1:0] i_llu_issue_rd,
    output logic                  o_llu_issue_rdy,
    input  logic                  i_llu_valid,
    input  logic [REG_ADDR_W-1:0] i_llu_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_llu_data,
    output logic                  o_llu_ready,
    input  logic [REG_ADDR_W-1:0] i_dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_dec_rs2_addr,
    input  logic                  i_dec_rd_we,
    input  logic [REG_ADDR_W-1:0] i_dec_rd_addr,
    output logic                  o_stall_decode,
    output logic                  o_req_bubble,
    output logic                  o_reg_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_write_data
);

    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW   = PW + 1;
    localparam int CW   = $clog2(MAX_OUTST + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    localparam logic [OW-1:0]         FIFO_FULL = OW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         CNT_MAX   = CW'(MAX_OUTST);
    localparam logic [SW-1:0]         STARVE_MX = SW'(STARVE_LIMIT);
    localparam logic [REG_ADDR_W-1:0] X0        = '0;

    // result FIFO storage and control
    logic [REG_ADDR_W-1:0] mem_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [OW-1:0]         occ;

    logic [NREG-1:0]       pend, pend_nxt;
    logic [CW-1:0]         outst;
    logic [SW-1:0]         starve;

    logic wb_act, fifo_empty, fifo_full, push, pop, issue_acc;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    assign wb_act     = i_wb_we && (i_wb_rd_addr != X0);
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == FIFO_FULL);
    assign head_rd    = mem_rd[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    // Pipeline writeback always wins; the FIFO drains only on idle wb cycles.
    assign pop  = !wb_act && !fifo_empty;
    // Full FIFO refuses a push even when it pops in the same cycle (no pass-through).
    assign push = i_llu_valid && !fifo_full;

    assign o_llu_ready     = !fifo_full;
    assign o_llu_issue_rdy = (outst < CNT_MAX) &&
                             ((i_llu_issue_rd == X0) || !pend[i_llu_issue_rd]);
    assign issue_acc       = i_llu_issue && o_llu_issue_rdy;

    // Write port mux
    always_comb begin
        o_reg_we        = 1'b0;
        o_rd_addr       = '0;
        o_rd_write_data = '0;
        if (wb_act) begin
            o_reg_we        = 1'b1;
            o_rd_addr       = i_wb_rd_addr;
            o_rd_write_data = i_wb_data;
        end else if (!fifo_empty) begin
            o_reg_we        = (head_rd != X0);
            o_rd_addr       = head_rd;
            o_rd_write_data = head_data;
        end
    end

    // Clear from the pop applied first so a same-cycle set on the same register wins.
    always_comb begin
        pend_nxt = pend;
        if (pop)
            pend_nxt[head_rd] = 1'b0;
        if (issue_acc && (i_llu_issue_rd != X0))
            pend_nxt[i_llu_issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Stall looks only at registered pend: a register popped at edge N is free in N+1.
    assign o_stall_decode = (pend[i_dec_rs1_addr] && (i_dec_rs1_addr != X0)) ||
                            (pend[i_dec_rs2_addr] && (i_dec_rs2_addr != X0)) ||
                            (i_dec_rd_we && pend[i_dec_rd_addr] && (i_dec_rd_addr != X0));

    assign o_req_bubble = (starve == STARVE_MX);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= i_llu_rd_addr;
            mem_data[wr_ptr] <= i_llu_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pend   <= '0;
            outst  <= '0;
            starve <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase

            pend <= pend_nxt;
            case ({issue_acc, pop})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase

            // Counts cycles the head is blocked by writeback; held at the limit until a pop.
            if (pop || fifo_empty)
                starve <= '0;
            else if (wb_act && (starve != STARVE_MX))
                starve <= starve + SW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Purpose: exercises regfile_wb_scheduler with directed scenarios and random traffic against a queue-based model.
// Latency: every cycle the DUT outputs are compared at the falling edge with values the model predicts.
// Backpressure: LLU results are offered from an in-flight list and retired only when the model says they were accepted.
module tb_regfile_wb_scheduler;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int DEPTH = 2;
    localparam int MAXO = 4;
    localparam int SLIM = 8;

    logic          i_clk = 1'b0;
    logic          i_arst = 1'b0;
    logic          i_wb_we, i_llu_issue, i_llu_valid, i_dec_rd_we;
    logic [AW-1:0] i_wb_rd_addr, i_llu_issue_rd, i_llu_rd_addr;
    logic [AW-1:0] i_dec_rs1_addr, i_dec_rs2_addr, i_dec_rd_addr;
    logic [DW-1:0] i_wb_data, i_llu_data;
    logic          o_llu_issue_rdy, o_llu_ready, o_stall_decode, o_req_bubble, o_reg_we;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] o_rd_write_data;

    regfile_wb_scheduler #(
        .DATA_WIDTH(DW), .REG_ADDR_W(AW), .FIFO_DEPTH(DEPTH),
        .MAX_OUTST(MAXO), .STARVE_LIMIT(SLIM)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_wb_we(i_wb_we), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_data(i_wb_data),
        .i_llu_issue(i_llu_issue), .i_llu_issue_rd(i_llu_issue_rd),
        .o_llu_issue_rdy(o_llu_issue_rdy),
        .i_llu_valid(i_llu_valid), .i_llu_rd_addr(i_llu_rd_addr), .i_llu_data(i_llu_data),
        .o_llu_ready(o_llu_ready),
        .i_dec_rs1_addr(i_dec_rs1_addr), .i_dec_rs2_addr(i_dec_rs2_addr),
        .i_dec_rd_we(i_dec_rd_we), .i_dec_rd_addr(i_dec_rd_addr),
        .o_stall_decode(o_stall_decode), .o_req_bubble(o_req_bubble),
        .o_reg_we(o_reg_we), .o_rd_addr(o_rd_addr), .o_rd_write_data(o_rd_write_data)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: result queue, pending set, outstanding count, starvation count.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   pend[32];
    int   outst;
    int   starve;
    bit   acc_issue, acc_llu;

    task automatic model_clear();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        outst  = 0;
        starve = 0;
    endtask

    task automatic set_idle();
        i_wb_we = 0; i_wb_rd_addr = 0; i_wb_data = 0;
        i_llu_issue = 0; i_llu_issue_rd = 0;
        i_llu_valid = 0; i_llu_rd_addr = 0; i_llu_data = 0;
        i_dec_rs1_addr = 0; i_dec_rs2_addr = 0; i_dec_rd_we = 0; i_dec_rd_addr = 0;
    endtask

    // One clock cycle: predict from current inputs, compare mid-cycle, advance model at the edge.
    task automatic step();
        bit            wb_act, empty, pop, e_we, e_rdy, e_ready, e_stall, e_bub;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        ent_t          head;
        wb_act  = i_wb_we && (i_wb_rd_addr != 0);
        empty   = (q.size() == 0);
        pop     = !wb_act && !empty;
        e_we = 0; e_addr = 0; e_data = 0;
        if (wb_act) begin
            e_we = 1; e_addr = i_wb_rd_addr; e_data = i_wb_data;
        end else if (!empty) begin
            e_we = (q[0].rd != 0); e_addr = q[0].rd; e_data = q[0].data;
        end
        e_ready = (q.size() < DEPTH);
        e_rdy   = (outst < MAXO) && ((i_llu_issue_rd == 0) || !pend[i_llu_issue_rd]);
        e_stall = (pend[i_dec_rs1_addr] && i_dec_rs1_addr != 0) ||
                  (pend[i_dec_rs2_addr] && i_dec_rs2_addr != 0) ||
                  (i_dec_rd_we && pend[i_dec_rd_addr] && i_dec_rd_addr != 0);
        e_bub   = (starve == SLIM);
        acc_issue = i_llu_issue && e_rdy;
        acc_llu   = i_llu_valid && e_ready;

        @(negedge i_clk);
        chk("reg_we", o_reg_we, e_we);
        chk("rd_addr", o_rd_addr, e_addr);
        chk("rd_data", o_rd_write_data, e_data);
        chk("llu_ready", o_llu_ready, e_ready);
        chk("issue_rdy", o_llu_issue_rdy, e_rdy);
        chk("stall", o_stall_decode, e_stall);
        chk("bubble", o_req_bubble, e_bub);

        @(posedge i_clk);
        if (pop) begin
            head = q.pop_front();
            pend[head.rd] = 1'b0;
            outst--;
        end
        if (acc_llu) q.push_back('{rd: i_llu_rd_addr, data: i_llu_data});
        if (acc_issue) begin
            outst++;
            if (i_llu_issue_rd != 0) pend[i_llu_issue_rd] = 1'b1;
        end
        if (pop || empty) starve = 0;
        else if (wb_act && starve < SLIM) starve++;
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without an edge.
    task automatic do_reset();
        set_idle();
        #2 i_arst = 0;
        #1;
        chk("rst_reg_we", o_reg_we, 1'b0);
        chk("rst_llu_ready", o_llu_ready, 1'b1);
        chk("rst_issue_rdy", o_llu_issue_rdy, 1'b1);
        chk("rst_bubble", o_req_bubble, 1'b0);
        model_clear();
        @(posedge i_clk);
        #1 i_arst = 1;
    endtask

    logic [AW-1:0] inflight[$];
    int            idx;

    initial begin
        set_idle();
        model_clear();
        #12;
        chk("rst_reg_we0", o_reg_we, 1'b0);
        chk("rst_ready0", o_llu_ready, 1'b1);
        chk("rst_issue0", o_llu_issue_rdy, 1'b1);
        chk("rst_stall0", o_stall_decode, 1'b0);
        @(posedge i_clk); #1 i_arst = 1;
        step();

        // Issue x5, stall on rs1=5, LLU returns 0xAB, write then unstall
        i_llu_issue = 1; i_llu_issue_rd = 5; step();
        set_idle(); i_dec_rs1_addr = 5; #1 chk("x5_stall", o_stall_decode, 1'b1); step();
        i_llu_valid = 1; i_llu_rd_addr = 5; i_llu_data = 64'hAB; step();
        set_idle(); i_dec_rs1_addr = 5; #1;
        chk("x5_we", o_reg_we, 1'b1); chk("x5_addr", o_rd_addr, 5); chk("x5_data", o_rd_write_data, 64'hAB);
        step();
        #1 chk("x5_unstall", o_stall_decode, 1'b0); step();

        // LLU x7 collides with wb x3; x3 first, x7 next cycle
        set_idle(); i_llu_issue = 1; i_llu_issue_rd = 7; step();
        set_idle(); i_llu_valid = 1; i_llu_rd_addr = 7; i_llu_data = 64'h77;
        i_wb_we = 1; i_wb_rd_addr = 3; i_wb_data = 64'h33;
        #1 chk("wb_wins_addr", o_rd_addr, 3); step();
        set_idle(); #1 chk("x7_addr", o_rd_addr, 7); chk("x7_data", o_rd_write_data, 64'h77); step();

        // Fill FIFO while wb busy; third result held; order preserved
        set_idle(); i_llu_issue = 1; i_llu_issue_rd = 8; step();
        #1 chk("dup_rd_rdy", o_llu_issue_rdy, 1'b0); step();
        i_llu_issue_rd = 9; step();
        i_llu_issue_rd = 10; step();
        set_idle(); i_wb_we = 1; i_wb_rd_addr = 1; i_wb_data = 64'h11;
        i_llu_valid = 1; i_llu_rd_addr = 8; i_llu_data = 64'h88; step();
        i_llu_rd_addr = 9; i_llu_data = 64'h99; step();
        i_llu_rd_addr = 10; i_llu_data = 64'hA0; #1 chk("full_ready", o_llu_ready, 1'b0); step();
        i_wb_we = 0; #1 chk("full_pop_ready", o_llu_ready, 1'b0); chk("pop8", o_rd_addr, 8); step();
        #1 chk("after_pop_ready", o_llu_ready, 1'b1); chk("pop9", o_rd_addr, 9); step();
        set_idle(); #1 chk("pop10", o_rd_write_data, 64'hA0); step();

        // Outstanding limit and rd=0 issues
        i_llu_issue = 1; i_llu_issue_rd = 0; step();
        set_idle(); i_dec_rd_we = 1; #1 chk("x0_nostall", o_stall_decode, 1'b0); step();
        for (int r = 11; r <= 13; r++) begin
            i_llu_issue = 1; i_llu_issue_rd = AW'(r); step();
        end
        i_llu_issue_rd = 15; #1 chk("max_outst", o_llu_issue_rdy, 1'b0); step();
        set_idle(); i_wb_we = 1; i_wb_rd_addr = 2; i_llu_valid = 1; i_llu_rd_addr = 11; step();
        do_reset();
        i_dec_rs1_addr = 11; #1 chk("rst_clears_pend", o_stall_decode, 1'b0); step();

        // Starvation: wb busy with a buffered result
        set_idle(); i_llu_issue = 1; i_llu_issue_rd = 20; step();
        set_idle(); i_wb_we = 1; i_wb_rd_addr = 2; i_llu_valid = 1; i_llu_rd_addr = 20; i_llu_data = 64'h20; step();
        i_llu_valid = 0;
        for (int k = 0; k < SLIM; k++) step();
        #1 chk("bubble_req", o_req_bubble, 1'b1); step();
        set_idle(); #1 chk("bubble_hold", o_req_bubble, 1'b1); chk("bubble_pop", o_rd_addr, 20); step();
        #1 chk("bubble_clear", o_req_bubble, 1'b0); step();

        // Random traffic; LLU results come back out of order from the in-flight list
        for (int c = 0; c < 600; c++) begin
            set_idle();
            i_wb_we      = ($urandom_range(0, 99) < 55);
            i_wb_rd_addr = AW'($urandom_range(0, 31));
            i_wb_data    = {$urandom, $urandom};
            i_llu_issue    = ($urandom_range(0, 99) < 35);
            i_llu_issue_rd = AW'($urandom_range(0, 7));
            idx = -1;
            if (inflight.size() != 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, inflight.size() - 1);
                i_llu_valid   = 1;
                i_llu_rd_addr = inflight[idx];
                i_llu_data    = {$urandom, $urandom};
            end
            i_dec_rs1_addr = AW'($urandom_range(0, 7));
            i_dec_rs2_addr = AW'($urandom_range(0, 7));
            i_dec_rd_we    = $urandom_range(0, 1) == 1;
            i_dec_rd_addr  = AW'($urandom_range(0, 7));
            if (c == 300) begin
                do_reset();
                inflight.delete();
                continue;
            end
            step();
            if (acc_llu && idx >= 0) inflight.delete(idx);
            if (acc_issue) inflight.push_back(i_llu_issue_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
